// File: rtl/spi_adc_capture.sv
// spi_adc_capture: periodic SPI ADC frame capture into a first-word
// fall-through sample FIFO with round-robin external channel select.
// Optional build macro: SIGNED_OUT_EN (store samples with MSB inverted,
// offset binary -> two's complement). Default build stores raw samples.
//
// state | meaning
// IDLE  | nSS=1, sCLK=1, waiting for a period tick while enable=1
// SETUP | nSS=0, sCLK=1 for CLK_DIV cycles before the first edge
// SHIFT | FRAME_BITS sCLK periods, MISO captured on each sCLK rise
// HOLD  | nSS=0, sCLK=1 for CLK_DIV cycles after the last rise
// PUSH  | nSS=1, one cycle: write sample to FIFO, advance chan_sel
module spi_adc_capture #(
  parameter int SAMPLE_W      = 12,
  parameter int FRAME_BITS    = 16,
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 2500,
  parameter int CHANNELS      = 1,
  parameter int FIFO_DEPTH    = 8,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                SystemClock,
  input  logic                btnCpuReset,
  input  logic                enable,
  input  logic                MISO,
  output logic                nSS,
  output logic                sCLK,
  output logic [CH_W-1:0]     chan_sel,
  output logic [SAMPLE_W-1:0] m_data,
  output logic [CH_W-1:0]     m_chan,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CH_W + SAMPLE_W;

  localparam logic [PW-1:0]   PER_LOAD = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0]   DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0]   BIT_LOAD = BW'(FRAME_BITS - 1);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANNELS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_PUSH  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [PW-1:0]         per_cnt_q, per_cnt_d;
  logic                  start_pend_q, start_pend_d;
  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  nss_q, nss_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CH_W-1:0]       chan_q, chan_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];

  logic                  start_req;
  logic                  go;
  logic                  push;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;
  logic [SAMPLE_W-1:0]   sample;

  // Free-running period timer; a cleared counter fires at once, so the first
  // cycle enable is seen high starts a frame.
  always_comb begin
    per_cnt_d = per_cnt_q;
    start_req = 1'b0;
    if (!enable) begin
      per_cnt_d = '0;
    end else if (per_cnt_q == '0) begin
      start_req = 1'b1;
      per_cnt_d = PER_LOAD;
    end else begin
      per_cnt_d = per_cnt_q - 1'b1;
    end
  end

  // Frame sequencer; a tick that lands while a frame is busy is held pending.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    sclk_d       = sclk_q;
    nss_d        = nss_q;
    shift_d      = shift_q;
    chan_d       = chan_q;
    push         = 1'b0;
    go           = enable & (start_pend_q | start_req);
    start_pend_d = go;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d      = S_SETUP;
          start_pend_d = 1'b0;
          nss_d        = 1'b0;
          div_cnt_d    = DIV_LOAD;
        end
      end
      S_SETUP: begin
        if (div_cnt_q == '0) begin
          state_d   = S_SHIFT;
          sclk_d    = 1'b0;
          div_cnt_d = DIV_LOAD;
          bit_cnt_d = BIT_LOAD;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = DIV_LOAD;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shift_d = (shift_q << 1) | FRAME_BITS'(MISO);
          end else if (bit_cnt_q == '0) begin
            state_d = S_HOLD;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (div_cnt_q == '0) begin
          state_d = S_PUSH;
          nss_d   = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      S_PUSH: begin
        state_d = S_IDLE;
        push    = 1'b1;
        chan_d  = (chan_q == CH_LAST) ? '0 : chan_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop in the same cycle frees room for a push when full.
  always_comb begin
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty   = (wr_ptr_q == rd_ptr_q);
    pop     = !empty && m_ready;
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    sample  = shift_q[SAMPLE_W-1:0];
`ifdef SIGNED_OUT_EN
    sample[SAMPLE_W-1] = ~shift_q[SAMPLE_W-1];
`else
    sample[SAMPLE_W-1] = shift_q[SAMPLE_W-1];
`endif
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = {chan_q, sample};
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge SystemClock) begin
    if (btnCpuReset) begin
      state_q      <= S_IDLE;
      per_cnt_q    <= '0;
      start_pend_q <= 1'b0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      sclk_q       <= 1'b1;
      nss_q        <= 1'b1;
      shift_q      <= '0;
      chan_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      start_pend_q <= start_pend_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sclk_q       <= sclk_d;
      nss_q        <= nss_d;
      shift_q      <= shift_d;
      chan_q       <= chan_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_q        <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge SystemClock) begin
    mem_q <= mem_d;
  end

  assign nSS      = nss_q;
  assign sCLK     = sclk_q;
  assign chan_sel = chan_q;
  assign m_valid  = !empty;
  assign m_data   = mem_q[rd_ptr_q[AW-1:0]][SAMPLE_W-1:0];
  assign m_chan   = mem_q[rd_ptr_q[AW-1:0]][EW-1:SAMPLE_W];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_spi_adc_capture.sv
// Testbench for spi_adc_capture: behavioural ADC on MISO, queue-based
// reference FIFO, scenario tasks run in sequence.
module tb_spi_adc_capture;

  localparam int CD    = 2;
  localparam int FB    = 16;
  localparam int SW    = 12;
  localparam int P     = 80;
  localparam int CH    = 3;
  localparam int DEPTH = 4;
  localparam int CHW   = 2;
`ifdef SIGNED_OUT_EN
  localparam logic [SW-1:0] SIGN_MASK = 12'h800;
`else
  localparam logic [SW-1:0] SIGN_MASK = 12'h000;
`endif

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [SW-1:0]  d;
  } ent_t;

  logic clk, rst, enable, MISO, nSS, sCLK, m_valid, m_ready, overflow, ovf_clr;
  logic [CHW-1:0] chan_sel, m_chan;
  logic [SW-1:0]  m_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int nfalls = 0;
  int fall_cyc[$];
  logic [FB-1:0] adc_q[$];
  logic [FB-1:0] frame_words[$];

  ent_t exp_q[$];
  int   mdl_chan = 0;
  bit   mdl_ovf = 0;

  spi_adc_capture #(
    .SAMPLE_W(SW), .FRAME_BITS(FB), .CLK_DIV(CD), .SAMPLE_PERIOD(P),
    .CHANNELS(CH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .SystemClock(clk), .btnCpuReset(rst), .enable(enable), .MISO(MISO),
    .nSS(nSS), .sCLK(sCLK), .chan_sel(chan_sel), .m_data(m_data),
    .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge nSS);
    nfalls++;
    fall_cyc.push_back(cyc);
  end

  initial forever begin
    @(posedge sCLK);
    if (nSS === 1'b0) rise_cnt++;
  end

  // ADC: presents the frame MSB first, next bit after each sCLK rise.
  initial begin
    logic [FB-1:0] cur;
    int idx;
    MISO = 1'b0;
    forever begin
      @(negedge nSS);
      cur = (adc_q.size() > 0) ? adc_q.pop_front() : FB'($urandom);
      frame_words.push_back(cur);
      idx = FB - 1;
      MISO = cur[idx];
      while (idx > 0) begin
        @(posedge sCLK or posedge nSS);
        if (nSS === 1'b1) break;
        idx--;
        MISO = cur[idx];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: one completed frame hands its sample to the FIFO.
  function automatic void model_frame(input logic [FB-1:0] w, input bit pop_now);
    ent_t e;
    e.ch = mdl_chan[CHW-1:0];
    e.d  = w[SW-1:0] ^ SIGN_MASK;
    if (pop_now && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else mdl_ovf = 1'b1;
    mdl_chan = (mdl_chan + 1) % CH;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    mdl_chan = 0;
    mdl_ovf = 1'b0;
    rise_cnt = 0;
  endtask

  // Waits for one frame; returns during the PUSH cycle (nSS back high).
  task automatic wait_frame(input int drop_at, output int low, output bit ok);
    int t;
    t = 0; low = 0; ok = 1'b0;
    while (nSS !== 1'b0 && t < 1000) begin @(posedge clk); #1; t++; end
    if (nSS !== 1'b0) return;
    while (nSS === 1'b0 && low < 1000) begin
      low++;
      if (low == drop_at + 1 && drop_at >= 0) enable = 1'b0;
      @(posedge clk); #1;
    end
    ok = (nSS === 1'b1);
  endtask

  task automatic test_reset();
    int f0;
    rst = 1'b1; enable = 1'b1; m_ready = 1'b0; ovf_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    f0 = nfalls;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (nSS !== 1'b1) begin errors++; $display("FAIL reset_nss: got %b need 1", nSS); end
    checks++; if (sCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b need 1", sCLK); end
    checks++; if (chan_sel !== 2'd0) begin errors++; $display("FAIL reset_chan_sel: got %0d need 0", chan_sel); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b need 0", m_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b need 0", overflow); end
    checks++; if (nfalls != f0) begin errors++; $display("FAIL reset_no_frame: falls %0d need %0d", nfalls, f0); end
    enable = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_single_frame();
    int low; bit ok; ent_t e;
    apply_reset();
    adc_q.push_back(16'h0B22);
    enable = 1'b1;
    wait_frame(0, low, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: frame not seen"); end
    checks++; if (low != 68) begin errors++; $display("FAIL single_nss_low: got %0d cycles need 68", low); end
    checks++; if (rise_cnt != 16) begin errors++; $display("FAIL single_rises: got %0d need 16", rise_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_in_push: got %b need 0", m_valid); end
    model_frame(frame_words[frame_words.size()-1], 1'b0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b need 1", m_valid); end
    checks++; if (m_data !== e.d) begin errors++; $display("FAIL single_data: got %h need %h", m_data, e.d); end
    checks++; if (m_chan !== 2'd0) begin errors++; $display("FAIL single_chan: got %0d need 0", m_chan); end
    m_ready = 1'b1; @(posedge clk); #1; m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_pop: m_valid %b need 0", m_valid); end
  endtask

  task automatic test_channels();
    int low; bit ok; int b; ent_t e;
    apply_reset();
    b = fall_cyc.size();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_frame((i == 3) ? 0 : -1, low, ok);
      checks++; if (!ok) begin errors++; $display("FAIL chan_timeout: frame %0d", i); end
      model_frame(frame_words[frame_words.size()-1], 1'b0);
    end
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (fall_cyc[b+i] - fall_cyc[b+i-1] != P) begin
        errors++; $display("FAIL chan_period: got %0d need %0d", fall_cyc[b+i] - fall_cyc[b+i-1], P);
      end
    end
    checks++; if (chan_sel !== mdl_chan[CHW-1:0]) begin errors++; $display("FAIL chan_sel_after: got %0d need %0d", chan_sel, mdl_chan); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (m_valid !== 1'b1 || m_data !== e.d || m_chan !== e.ch) begin
        errors++; $display("FAIL chan_entry: got v%b %h ch%0d need v1 %h ch%0d", m_valid, m_data, m_chan, e.d, e.ch);
      end
      m_ready = 1'b1; @(posedge clk); #1; m_ready = 1'b0;
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL chan_empty: m_valid %b need 0", m_valid); end
  endtask

  task automatic test_overflow();
    int low; bit ok; ent_t e;
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_frame((i == 4) ? 0 : -1, low, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: frame %0d", i); end
      model_frame(frame_words[frame_words.size()-1], 1'b0);
      @(posedge clk); #1;
      checks++;
      if (overflow !== mdl_ovf) begin errors++; $display("FAIL ovf_flag: frame %0d got %b need %b", i, overflow, mdl_ovf); end
    end
    repeat (3) @(posedge clk); #1;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b need 1", overflow); end
    ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
    mdl_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b need 0", overflow); end
    enable = 1'b1;
    wait_frame(0, low, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout6: frame not seen"); end
    model_frame(frame_words[frame_words.size()-1], 1'b0);
    ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b need 1", overflow); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (m_valid !== 1'b1 || m_data !== e.d || m_chan !== e.ch) begin
        errors++; $display("FAIL ovf_entry: got v%b %h ch%0d need v1 %h ch%0d", m_valid, m_data, m_chan, e.d, e.ch);
      end
      m_ready = 1'b1; @(posedge clk); #1; m_ready = 1'b0;
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: m_valid %b need 0", m_valid); end
  endtask

  task automatic test_full_pop();
    int low; bit ok; ent_t e;
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_frame((i == 4) ? 0 : -1, low, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fullpop_timeout: frame %0d", i); end
      if (i == 4) m_ready = 1'b1;
      model_frame(frame_words[frame_words.size()-1], i == 4);
      @(posedge clk); #1;
      m_ready = 1'b0;
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b need 0", overflow); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (m_valid !== 1'b1 || m_data !== e.d || m_chan !== e.ch) begin
        errors++; $display("FAIL fullpop_entry: got v%b %h ch%0d need v1 %h ch%0d", m_valid, m_data, m_chan, e.d, e.ch);
      end
      m_ready = 1'b1; @(posedge clk); #1; m_ready = 1'b0;
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty: m_valid %b need 0", m_valid); end
  endtask

  task automatic test_enable_drop_reset();
    int low; bit ok; int f0; int t; ent_t e;
    apply_reset();
    enable = 1'b1;
    wait_frame($urandom_range(8, 60), low, ok);
    checks++; if (!ok || low != 68) begin errors++; $display("FAIL drop_frame: ok %b low %0d need 68", ok, low); end
    model_frame(frame_words[frame_words.size()-1], 1'b0);
    f0 = nfalls;
    repeat (3 * P) @(posedge clk); #1;
    checks++; if (nfalls != f0) begin errors++; $display("FAIL drop_no_restart: falls %0d need %0d", nfalls, f0); end
    e = exp_q[0];
    checks++;
    if (m_valid !== 1'b1 || m_data !== e.d || m_chan !== e.ch) begin
      errors++; $display("FAIL drop_entry: got v%b %h ch%0d need v1 %h ch%0d", m_valid, m_data, m_chan, e.d, e.ch);
    end
    enable = 1'b1;
    t = 0;
    while (!(nSS === 1'b0 && sCLK === 1'b0) && t < 1000) begin @(posedge clk); #1; t++; end
    checks++; if (t >= 1000) begin errors++; $display("FAIL rst_shift_timeout: SHIFT not reached"); end
    repeat ($urandom_range(1, 40)) @(posedge clk);
    #1 rst = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    checks++; if (nSS !== 1'b1) begin errors++; $display("FAIL rst_mid_nss: got %b need 1", nSS); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b need 0", m_valid); end
    rst = 1'b0;
    repeat (2 * P) @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0 || nSS !== 1'b1) begin errors++; $display("FAIL rst_no_write: m_valid %b nSS %b need 0 1", m_valid, nSS); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_single_frame();
    test_channels();
    test_overflow();
    test_full_pop();
    test_enable_drop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_adc_capture.md
SPI_ADC_CAPTURE -- requirements
Module: spi_adc_capture

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 12: sample bits kept per frame, 1..FRAME_BITS.
REQ-002 SHALL have parameter FRAME_BITS, default 16: sCLK cycles per conversion frame.
REQ-003 SHALL have parameter CLK_DIV, default 50: SystemClock cycles per sCLK half-period, >=1.
REQ-004 SHALL have parameter SAMPLE_PERIOD, default 2500: SystemClock cycles between frame starts, >= (2*FRAME_BITS+2)*CLK_DIV.
REQ-005 SHALL have parameter CHANNELS, default 1: round-robin channel count, 1..4; CH_W = max(1, clog2(CHANNELS)).
REQ-006 SHALL have parameter FIFO_DEPTH, default 8: sample FIFO entries, a power of two >=2.
REQ-007 SHALL have port SystemClock, input, 1: the single clock.
REQ-008 SHALL have port btnCpuReset, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port enable, input, 1: when high, frames start every SAMPLE_PERIOD cycles.
REQ-010 SHALL have port MISO, input, 1: ADC serial data, MSB first.
REQ-011 SHALL have ports nSS (output, 1, active-low chip select) and sCLK (output, 1, serial clock, idles high).
REQ-012 SHALL have port chan_sel, output, CH_W: external mux select for the channel of the current or next frame.
REQ-013 SHALL have ports m_data (output, SAMPLE_W), m_chan (output, CH_W), m_valid (output, 1), m_ready (input, 1): FIFO read side.
REQ-014 SHALL have ports overflow (output, 1, sticky) and ovf_clr (input, 1).

Function
REQ-015 SHALL run the FSM IDLE -> SETUP -> SHIFT -> HOLD -> PUSH -> IDLE.
REQ-016 IDLE: nSS=1, sCLK=1; the period counter SHALL count continuously while enable=1; on terminal count (or on the first cycle enable is seen high after reset or disable) the FSM SHALL enter SETUP.
REQ-017 SETUP SHALL last CLK_DIV cycles with nSS=0, sCLK=1.
REQ-018 SHIFT SHALL produce FRAME_BITS sCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
REQ-019 MISO SHALL be sampled on the SystemClock edge at which sCLK goes 0->1 and shifted into the LSB of a FRAME_BITS register.
REQ-020 HOLD SHALL last CLK_DIV cycles with nSS=0, sCLK=1; PUSH is one cycle with nSS=1.
REQ-021 PUSH SHALL write {chan_sel, shift_reg[SAMPLE_W-1:0]} into the FIFO, then advance chan_sel modulo CHANNELS, wrapping CHANNELS-1 to 0.
REQ-022 Deassertion of enable mid-frame SHALL NOT abort the frame; the frame completes, including PUSH, and the FSM then idles.
REQ-023 The FIFO SHALL be first-word fall-through: m_valid=1 whenever it is non-empty, and m_data/m_chan show the oldest entry.
REQ-024 An entry SHALL be visible on m_valid the cycle after PUSH; a pop SHALL occur on each cycle with m_valid & m_ready.
REQ-025 PUSH while full with no pop that cycle SHALL drop the sample, leave the FIFO unchanged, and set overflow.
REQ-026 PUSH while full with a simultaneous pop SHALL succeed and SHALL NOT set overflow.
REQ-027 overflow SHALL clear on ovf_clr unless a drop occurs the same cycle; set wins.

Reset
REQ-028 btnCpuReset SHALL force state IDLE, nSS=1, sCLK=1, chan_sel=0, FIFO empty (m_valid=0), overflow=0, all counters and the shift register 0, within the same clock edge.
REQ-029 Reset mid-frame SHALL abandon the frame with no FIFO write.

Configuration
REQ-030 With SIGNED_OUT_EN defined, PUSH SHALL store the sample with its MSB inverted (offset binary converted to two's complement); without it, the sample SHALL be stored unmodified.

Verification
REQ-031 Use CLK_DIV=2, FRAME_BITS=16, SAMPLE_W=12 and MISO frame 0x0B22 -> nSS low for 68 cycles, exactly 16 sCLK rises, m_data=0xB22, m_chan=0 (0x322 with SIGNED_OUT_EN).
REQ-032 Use CHANNELS=3 and 4 frames -> m_chan sequence 0,1,2,0 and chan_sel=1 afterwards.
REQ-033 Use FIFO_DEPTH=4, m_ready=0, 5 frames -> 4 entries held with the first 4 values, overflow=1; pulse ovf_clr -> overflow=0.
REQ-034 FIFO full with m_ready=1 during the 5th PUSH -> first entry popped, 5th stored, overflow stays 0.
REQ-035 Drop enable during SHIFT -> frame completes and is pushed, no further nSS falling edge; assert btnCpuReset in the next frame's SHIFT -> nSS=1 and m_valid=0 next cycle.
